// File: rtl/quad_capture_frame_if.sv
// Pin, control and frame signals of the quadrature capture engine.
// The DUT attaches through the slave modport and the driving side through master.
interface quad_capture_frame_if #(
  parameter int NUM_CH    = 5,
  parameter int CNT_WIDTH = 32
);
  logic [NUM_CH-1:0]           quad_a;
  logic [NUM_CH-1:0]           quad_b;
  logic                        snap_req;
  logic                        clr_req;
  logic [NUM_CH-1:0]           clr_mask;
  logic [NUM_CH*CNT_WIDTH-1:0] counts;
  logic [31:0]                 time_now;
  logic [(NUM_CH+3)*32-1:0]    frame_data;
  logic                        frame_valid;
  logic                        busy;

  modport master (
    output quad_a, quad_b, snap_req, clr_req, clr_mask,
    input  counts, time_now, frame_data, frame_valid, busy
  );

  modport slave (
    input  quad_a, quad_b, snap_req, clr_req, clr_mask,
    output counts, time_now, frame_data, frame_valid, busy
  );
endinterface

// File: rtl/quad_capture_frame.sv
// Multi-channel 4x quadrature decoder with prescaled timestamp and a
// snapshot frame {time, counters, status, CRC-32/MPEG-2} built on request.
module quad_capture_frame #(
  parameter int NUM_CH      = 5,
  parameter int CNT_WIDTH   = 32,
  parameter int TICK_DIV    = 50,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 reset,
  quad_capture_frame_if.slave bus
);
  localparam int NW    = NUM_CH + 2;
  localparam int PW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IW    = $clog2(NW);
  localparam int FILLW = $clog2(SYNC_STAGES + 1);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {IDLE, CRC, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_a, sync_b;
  logic [NUM_CH-1:0]                  cur_a, cur_b, prev_a, prev_b, primed;
  logic [FILLW-1:0]                   fill;
  logic [NUM_CH-1:0]                  inc, dec, err_evt;
  logic [NUM_CH-1:0][1:0]             move;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]   cnt;

  logic [PW-1:0]       presc;
  logic [31:0]         tstamp;
  logic [7:0]          seq;
  logic [NUM_CH-1:0]   err;
  logic                overrun;
  logic [31:0]         status_nxt;
  logic [NW*32-1:0]    snap_words, shadow, shadow_rot;
  logic [31:0]         crc, crc_nxt;
  logic [IW-1:0]       idx;
  logic [(NUM_CH+3)*32-1:0] frame;

  logic accept, last, ov_evt, busy, frame_valid;

  function automatic logic [1:0] quad_pos(input logic a, input logic b);
    return {b, a ^ b};
  endfunction

  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int unsigned b = 0; b < 32; b++)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ w[31-b]) ? POLY : '0);
    return r;
  endfunction

  assign cur_a = sync_a[SYNC_STAGES-1];
  assign cur_b = sync_b[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.quad_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.quad_b};
    end
  end

  // Position along 00->10->11->01; a step of 2 means both pins moved at once.
  always_comb begin
    inc     = '0;
    dec     = '0;
    err_evt = '0;
    move    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      move[i] = quad_pos(cur_a[i], cur_b[i]) - quad_pos(prev_a[i], prev_b[i]);
      if (primed[i]) begin
        inc[i]     = (move[i] == 2'd1);
        dec[i]     = (move[i] == 2'd3);
        err_evt[i] = (move[i] == 2'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill   <= '0;
      primed <= '0;
      prev_a <= '0;
      prev_b <= '0;
      cnt    <= '0;
    end else begin
      if (fill != FILLW'(SYNC_STAGES)) fill <= fill + FILLW'(1);
      else                             primed <= '1;
      prev_a <= cur_a;
      prev_b <= cur_b;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.clr_req && bus.clr_mask[i]) cnt[i] <= '0;
        else if (inc[i])                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        else if (dec[i])                    cnt[i] <= cnt[i] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      tstamp <= '0;
    end else if (presc == PW'(TICK_DIV - 1)) begin
      presc  <= '0;
      tstamp <= tstamp + 32'd1;
    end else begin
      presc  <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    last        = 1'b0;
    ov_evt      = 1'b0;
    busy        = 1'b0;
    frame_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.snap_req) begin
          accept    = 1'b1;
          state_nxt = CRC;
        end
      end
      CRC: begin
        busy   = 1'b1;
        ov_evt = bus.snap_req;
        if (idx == IW'(NW - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        frame_valid = 1'b1;
        ov_evt      = bus.snap_req;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    status_nxt              = '0;
    status_nxt[NUM_CH-1:0]  = err;
    status_nxt[15]          = overrun;
    status_nxt[31:24]       = seq + 8'd1;
    snap_words              = '0;
    snap_words[NW*32-1 -: 32] = tstamp;
    for (int unsigned i = 0; i < NUM_CH; i++)
      snap_words[(NW-1-i)*32-1 -: 32] = 32'(signed'(cnt[i]));
    snap_words[31:0] = status_nxt;
  end

  // The shadow rotates one word per CRC cycle so the word being hashed is
  // always in the top slot; one more rotation restores frame order.
  assign shadow_rot = {shadow[NW*32-33:0], shadow[NW*32-1 -: 32]};
  assign crc_nxt    = crc_word(crc, shadow[NW*32-1 -: 32]);

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      crc     <= '0;
      idx     <= '0;
      seq     <= '0;
      err     <= '0;
      overrun <= '0;
      frame   <= '0;
    end else begin
      err     <= err | err_evt;
      overrun <= overrun | ov_evt;
      if (accept) begin
        shadow  <= snap_words;
        crc     <= '1;
        idx     <= '0;
        seq     <= seq + 8'd1;
        err     <= err_evt;
        overrun <= ov_evt;
      end
      if (state == CRC) begin
        crc    <= crc_nxt;
        shadow <= shadow_rot;
        idx    <= idx + IW'(1);
      end
      if (last) frame <= {shadow_rot, crc_nxt};
    end
  end

  assign bus.counts      = cnt;
  assign bus.time_now    = tstamp;
  assign bus.frame_data  = frame;
  assign bus.frame_valid = frame_valid;
  assign bus.busy        = busy;
endmodule

// File: doc/quad_capture_frame.md
Name: quad_capture_frame

Overview:
Parametrised multi-channel quadrature capture engine that sits between the encoder input pins and the SPI slave.
- Synchronises the A/B inputs, decodes 4x quadrature into per-channel counters and flags illegal transitions.
- Runs a prescaled timestamp.
- On snap_req, takes a coherent snapshot and builds a fixed frame: time, counters, status, CRC-32. The frame is presented as one wide vector that the SPI slave loads as tx_data.

Parameters:
NUM_CH, 5, number of quadrature channels (1..16)
CNT_WIDTH, 32, counter width (8..32); sign-extended to 32 bits in the frame
TICK_DIV, 50, clk cycles per timestamp tick (>=2)
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
quad_a  in  NUM_CH  channel A inputs, asynchronous; bit i = channel i
quad_b  in  NUM_CH  channel B inputs, asynchronous
snap_req  in  1  single-cycle request to capture and build a frame
clr_req  in  1  single-cycle counter clear strobe
clr_mask  in  NUM_CH  channels cleared when clr_req=1
counts  out  NUM_CH*CNT_WIDTH  live counters; channel 0 in the LSBs
time_now  out  32  live timestamp
frame_data  out  (NUM_CH+3)*32  last completed frame, word 0 in the MSBs
frame_valid  out  1  one-cycle pulse when frame_data updates
busy  out  1  frame build in progress

Behaviour:
Reset values:
- All counters, time_now, prescaler, sequence number, error bits, overrun bit, shadow registers, frame_data: 0.
- frame_valid=0, busy=0, FSM in IDLE.
- Synchroniser flops: 0.
- Per-channel primed flag: 0.

Synchroniser and priming:
- Each pin passes through SYNC_STAGES flops.
- The decoder compares the current synchronised {a,b} with the previous synchronised {a,b}.
- primed is set after the first valid synchronised sample. While primed=0, the previous sample is loaded with no count and no error.
- A pin edge changes the counter SYNC_STAGES+1 clocks later.

Decode, per channel, with {a,b}:
- +1 for transitions 00->10->11->01->00.
- -1 for the reverse sequence.
- No change: nothing.
- Both bits change in one sample: no count, sticky err[i] set.
- Counters wrap modulo 2^CNT_WIDTH.
- clr_req with clr_mask[i]=1 forces counter i to 0 that cycle. Clear wins over a simultaneous count.

Timestamp:
- Prescaler counts 0..TICK_DIV-1.
- On the cycle it equals TICK_DIV-1 it returns to 0 and time_now increments, i.e. exactly one increment per TICK_DIV clocks.
- time_now wraps at 2^32.

Status word:
- [31:24] seq: accepted-snapshot count, mod 256, value after increment.
- [23:16] 0.
- [15] overrun.
- [14:NUM_CH] 0.
- [NUM_CH-1:0] err.

FSM (IDLE, CRC, DONE):
- IDLE with snap_req=1, cycle 0:
  - Shadow regs capture time_now, all counters (pre-clear and pre-update values as registered that cycle), err, overrun, seq+1.
  - Same edge: err and overrun clear, seq increments. An error or overrun event in that same cycle sets its bit again (stays set for the next frame).
  - Go to CRC.
- CRC, cycles 1..NUM_CH+2:
  - busy=1.
  - One 32-bit word per cycle in frame order: time, ctr0..ctr(NUM_CH-1), status.
  - CRC-32/MPEG-2: poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no reflection, no final XOR.
- DONE, cycle NUM_CH+3:
  - frame_data loaded with {time, ctr0..ctrN-1, status, crc} in a single write.
  - frame_valid=1, busy=0, return to IDLE.
  - snap_req is accepted in the cycle after DONE.
- snap_req while busy=1 or in DONE: ignored, overrun set.
- frame_data is held stable between frame_valid pulses.
- Reset mid-build: FSM to IDLE, frame_data=0, no frame_valid.

Test Plan:
1. Reset, then A/B toggled through 4 forward sequences on ch0 -> counts[ch0]=16 after the last edge +SYNC_STAGES+1; 4 reverse sequences -> 0; reverse from 0 -> 0xFFFFFFFF.
2. ch2 {a,b} 00->11 in one step -> ch2 count unchanged; next frame status[2]=1, seq=1; following frame status[2]=0.
3. Hold TICK_DIV=50 for 5000 clocks from reset -> time_now=100. snap_req at clock 5000 -> frame word0=100; frame_valid exactly NUM_CH+3=8 cycles later, busy high for cycles 1..7.
4. Known counters (time=0x12345678, ctr=1..5) -> frame crc equals the software CRC-32/MPEG-2 model over the 7 big-endian words; word layout checked MSB-first.
5. snap_req at cycles 0 and 3 -> only one frame_valid; next frame status[15]=1, seq increments by 1 per accepted request only.
6. clr_req mask=0b00010 coincident with a ch1 forward count and with snap_req -> ch1 live=0; snapshot word for ch1 holds the pre-clear value.
